// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared types, constants and constant functions for the
//                CORDIC engine. The fixed-point constants are the default
//                Q=4/F=36 values. Modules with other widths call the
//                functions with their own F.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int Q_DEF = 4;
    localparam int F_DEF = 36;
    localparam int W_DEF = Q_DEF + F_DEF;

    typedef logic signed [W_DEF-1:0] fixed_t;

    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } mode_t;

    localparam real PI_R = 3.14159265358979323846;

    // Round a real value to a fixed-point number with f fraction bits.
    function automatic logic [63:0] real_to_fx(input real r, input int f);
        return 64'(longint'(r * (2.0 ** f)));
    endfunction

    // ATAN[i] = round(atan(2^-i) * 2^f)
    function automatic logic [63:0] atan_fx(input int i, input int f);
        return real_to_fx($atan(2.0 ** (-i)), f);
    endfunction

    // 1/An for a given number of micro-rotations.
    function automatic logic [63:0] cordic_k_fx(input int iters, input int f);
        real k;
        k = 1.0;
        for (int i = 0; i < iters; i++) begin
            k = k / $sqrt(1.0 + 2.0 ** (-2 * i));
        end
        return real_to_fx(k, f);
    endfunction

    localparam fixed_t CORDIC_K = fixed_t'(cordic_k_fx(32, F_DEF));
    localparam fixed_t PI       = fixed_t'(real_to_fx(PI_R, F_DEF));
    localparam fixed_t PI_2     = fixed_t'(real_to_fx(PI_R / 2.0, F_DEF));

endpackage
`default_nettype wire

// File: rtl/cordic_unroll.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_unroll
//  Description : Combinational slice of UNROLL consecutive CORDIC
//                micro-rotations. It starts at iteration index base.
//  Ports       : x, y, z      - current datapath values
//                mode         - MODE_ROT (steer on z) / MODE_VEC (steer on y)
//                base         - iteration index of the first stage
//                x_next, ...  - values after UNROLL micro-rotations
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_unroll
    import cordic_pkg::*;
#(
    parameter int Q      = Q_DEF,
    parameter int F      = F_DEF,
    parameter int ITERS  = 32,
    parameter int UNROLL = 4,
    localparam int W     = Q + F,
    localparam int IW    = (ITERS > 1) ? $clog2(ITERS) : 1
) (
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    input  logic [W-1:0]  z,
    input  mode_t         mode,
    input  logic [IW-1:0] base,
    output logic [W-1:0]  x_next,
    output logic [W-1:0]  y_next,
    output logic [W-1:0]  z_next
);

    logic signed [W-1:0] w_atan [ITERS];
    logic signed [W-1:0] w_x [UNROLL+1];
    logic signed [W-1:0] w_y [UNROLL+1];
    logic signed [W-1:0] w_z [UNROLL+1];

    // The arctangent table is fixed at elaboration and indexed at run time.
    for (genvar i = 0; i < ITERS; i++) begin : g_atan
        localparam logic [W-1:0] c_atan = W'(atan_fx(i, F));
        assign w_atan[i] = c_atan;
    end

    assign w_x[0] = x;
    assign w_y[0] = y;
    assign w_z[0] = z;

    for (genvar k = 0; k < UNROLL; k++) begin : g_stage
        logic [IW-1:0]       w_idx;
        logic                w_pos;
        logic signed [W-1:0] w_xs;
        logic signed [W-1:0] w_ys;

        assign w_idx = base + IW'(k);
        assign w_xs  = w_x[k] >>> w_idx;
        assign w_ys  = w_y[k] >>> w_idx;
        // d = +1: rotate mode when z >= 0, vector mode when y < 0
        assign w_pos = (mode == MODE_ROT) ? ~w_z[k][W-1] : w_y[k][W-1];

        assign w_x[k+1] = w_pos ? (w_x[k] - w_ys) : (w_x[k] + w_ys);
        assign w_y[k+1] = w_pos ? (w_y[k] + w_xs) : (w_y[k] - w_xs);
        assign w_z[k+1] = w_pos ? (w_z[k] - w_atan[w_idx]) : (w_z[k] + w_atan[w_idx]);
    end

    assign x_next = w_x[UNROLL];
    assign y_next = w_y[UNROLL];
    assign z_next = w_z[UNROLL];

endmodule
`default_nettype wire

// File: rtl/cordic_engine.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_engine
//  Description : Iterative dual-mode CORDIC with one operation in flight.
//                It runs UNROLL micro-rotations per enabled clock.
//                ROTATE: angle -> (cos, sin). VECTOR: (x, y) -> (An*|v|, atan2).
//                Optional macro CORDIC_RANGE_RED_EN extends the input range
//                to the full circle.
//  Ports       : clk, rst (async, active high), clk_en (global freeze)
//                in_valid/in_ready, in_mode, in_x, in_y, in_z - operand side
//                out_valid/out_ready, res_x, res_y, res_z      - result side
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int Q      = Q_DEF,
    parameter int F      = F_DEF,
    parameter int ITERS  = 32,
    parameter int UNROLL = 4,
    localparam int W     = Q + F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic [W-1:0] in_z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res_x,
    output logic [W-1:0] res_y,
    output logic [W-1:0] res_z
);

    localparam int PASSES = ITERS / UNROLL;
    localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int IW     = (ITERS > 1) ? $clog2(ITERS) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [W-1:0] c_k = W'(cordic_k_fx(ITERS, F));
`ifdef CORDIC_RANGE_RED_EN
    localparam logic signed [W-1:0] c_pi    = W'(real_to_fx(PI_R, F));
    localparam logic signed [W-1:0] c_pi_2  = W'(real_to_fx(PI_R / 2.0, F));
    localparam logic signed [W-1:0] c_npi   = -c_pi;
    localparam logic signed [W-1:0] c_npi_2 = -c_pi_2;
`endif

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [PW-1:0] r_pass;
    logic [W-1:0]  r_x, r_y, r_z;
    mode_t         r_mode;
    logic          r_neg;
    logic          w_accept;
    logic          w_last;
    logic [IW-1:0] w_base;
    logic [W-1:0]  w_x0, w_y0, w_z0;
    logic          w_neg;
    logic [W-1:0]  w_xn, w_yn, w_zn;

    assign w_last   = (r_state == c_st_busy) && (r_pass == PW'(PASSES - 1));
    assign w_accept = in_valid & in_ready;
    assign w_base   = IW'(r_pass * UNROLL);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else if (clk_en) begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (in_valid) w_next = c_st_busy;
            c_st_busy: if (w_last)   w_next = c_st_done;
            c_st_done: if (out_ready) w_next = in_valid ? c_st_busy : c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    // ---------------- outputs of the state machine ----------------
    always_comb begin
        in_ready  = (r_state == c_st_idle) || ((r_state == c_st_done) && out_ready);
        out_valid = (r_state == c_st_done);
    end

    // Starting values for the iteration. Range reduction folds the operand
    // into the convergent half-plane.
    always_comb begin
        w_x0  = in_x;
        w_y0  = in_y;
        w_z0  = '0;
        w_neg = 1'b0;
        if (mode_t'(in_mode) == MODE_ROT) begin
            w_x0 = c_k;
            w_y0 = '0;
            w_z0 = in_z;
`ifdef CORDIC_RANGE_RED_EN
            if ($signed(in_z) > c_pi_2) begin
                w_z0  = c_pi - in_z;
                w_neg = 1'b1;
            end else if ($signed(in_z) < c_npi_2) begin
                w_z0  = c_npi - in_z;
                w_neg = 1'b1;
            end
`endif
        end else begin
`ifdef CORDIC_RANGE_RED_EN
            if (in_x[W-1]) begin
                w_x0 = -in_x;
                w_y0 = -in_y;
                w_z0 = in_y[W-1] ? c_npi : c_pi;
            end
`endif
        end
    end

    cordic_unroll #(
        .Q      (Q),
        .F      (F),
        .ITERS  (ITERS),
        .UNROLL (UNROLL)
    ) u_unroll (
        .x      (r_x),
        .y      (r_y),
        .z      (r_z),
        .mode   (r_mode),
        .base   (w_base),
        .x_next (w_xn),
        .y_next (w_yn),
        .z_next (w_zn)
    );

    // ---------------- datapath and result registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_pass <= '0;
            r_mode <= MODE_ROT;
            r_neg  <= 1'b0;
            res_x  <= '0;
            res_y  <= '0;
            res_z  <= '0;
        end else if (clk_en) begin
            if (w_accept) begin
                r_x    <= w_x0;
                r_y    <= w_y0;
                r_z    <= w_z0;
                r_pass <= '0;
                r_mode <= mode_t'(in_mode);
                r_neg  <= w_neg;
            end else if (r_state == c_st_busy) begin
                r_x    <= w_xn;
                r_y    <= w_yn;
                r_z    <= w_zn;
                r_pass <= w_last ? '0 : r_pass + 1'b1;
                // The last pass goes straight to the result registers.
                // This lets out_valid rise on the same edge.
                if (w_last) begin
                    res_x <= r_neg ? -w_xn : w_xn;
                    res_y <= w_yn;
                    res_z <= w_zn;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_engine
//  Description : Self-checking bench for cordic_engine. A behavioural
//                CORDIC model plus handshake scoreboard is checked every
//                cycle. Directed literal cases pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_engine;

    localparam int    W      = 40;
    localparam int    ITERS  = 32;
    localparam int    PASSES = 8;
    localparam real   SCALE  = 68719476736.0;           // 2^36
    localparam real   M_PI   = 3.14159265358979323846;
    localparam real   TOL    = 1.0 / 268435456.0;       // 2^-28

    logic         clk = 1'b0;
    logic         rst, clk_en, in_valid, in_mode, out_ready;
    logic [W-1:0] in_x, in_y, in_z;
    logic         in_ready, out_valid;
    logic [W-1:0] res_x, res_y, res_z;

    int tests = 0;
    int fails = 0;

    cordic_engine dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_x     (res_x),
        .res_y     (res_y),
        .res_z     (res_z)
    );

    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic longint sx(input longint v);
        return (v <<< (64 - W)) >>> (64 - W);
    endfunction

    function automatic longint fx(input real r);
        return longint'(r * SCALE);
    endfunction

    function automatic real fr(input logic [W-1:0] v);
        longint t;
        t = longint'(v);
        return real'(sx(t)) / SCALE;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_fx(input string name, input logic [W-1:0] act, input longint exp);
        longint a, d;
        a = sx(longint'(act));
        d = a - exp;
        tests++;
        if (d > 4 || d < -4) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, a, exp, $time);
        end
    endtask

    task automatic chk_real(input string name, input real act, input real exp);
        real d;
        d = act - exp;
        tests++;
        if (d > TOL || d < -TOL) begin
            fails++;
            $display("FAIL %s: got %.10f expected %.10f", name, act, exp);
        end
    endtask

    // ---------------- behavioural CORDIC model ----------------
    function automatic void model(input bit mode, input longint ix, input longint iy,
                                  input longint iz, output longint ox, output longint oy,
                                  output longint oz);
        longint x, y, z, xs, ys, at;
        real    k;
        bit     neg, pos;
        k = 1.0;
        for (int i = 0; i < ITERS; i++) k = k * $cos($atan(2.0 ** (-i)));
        neg = 1'b0;
        if (!mode) begin
            x = fx(k); y = 0; z = iz;
`ifdef CORDIC_RANGE_RED_EN
            if (iz > fx(M_PI / 2.0)) begin
                z = sx(fx(M_PI) - iz); neg = 1'b1;
            end else if (iz < -fx(M_PI / 2.0)) begin
                z = sx(-fx(M_PI) - iz); neg = 1'b1;
            end
`endif
        end else begin
            x = ix; y = iy; z = 0;
`ifdef CORDIC_RANGE_RED_EN
            if (ix < 0) begin
                x = sx(-ix); y = sx(-iy); z = (iy >= 0) ? fx(M_PI) : -fx(M_PI);
            end
`endif
        end
        for (int i = 0; i < ITERS; i++) begin
            pos = mode ? (y < 0) : (z >= 0);
            xs  = x >>> i;
            ys  = y >>> i;
            at  = fx($atan(2.0 ** (-i)));
            if (pos) begin
                x = sx(x - ys); y = sx(y + xs); z = sx(z - at);
            end else begin
                x = sx(x + ys); y = sx(y - xs); z = sx(z + at);
            end
        end
        ox = neg ? sx(-x) : x;
        oy = y;
        oz = z;
    endfunction

    // ---------------- compare process ----------------
    // Handshake scoreboard: 0 idle, 1 busy, 2 result held
    int     m_state = 0;
    int     m_cnt   = 0;
    longint ex, ey, ez;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", longint'(in_ready), 1);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_res_x", longint'(res_x), 0);
            chk("rst_res_y", longint'(res_y), 0);
            chk("rst_res_z", longint'(res_z), 0);
            m_state = 0;
        end else begin
            chk("out_valid", longint'(out_valid), longint'(m_state == 2));
            chk("in_ready", longint'(in_ready),
                longint'(m_state == 0 || (m_state == 2 && out_ready)));
            if (m_state == 2) begin
                chk_fx("res_x", res_x, ex);
                chk_fx("res_y", res_y, ey);
                chk_fx("res_z", res_z, ez);
            end
            if (clk_en) begin
                if (m_state == 1) begin
                    m_cnt++;
                    if (m_cnt == PASSES) m_state = 2;
                end else if (m_state == 0 || (m_state == 2 && out_ready)) begin
                    if (in_valid) begin
                        model(in_mode, sx(longint'(in_x)), sx(longint'(in_y)),
                              sx(longint'(in_z)), ex, ey, ez);
                        m_state = 1;
                        m_cnt   = 0;
                    end else begin
                        m_state = 0;
                    end
                end
            end
        end
    end

    // ---------------- directed operation ----------------
    task automatic op(input bit mode, input real a, input real b, input real c,
                      output real rx, output real ry, output real rz);
        int n;
        @(posedge clk); #1;
        clk_en = 1; in_mode = mode; in_valid = 1; out_ready = 0;
        in_x = W'(fx(a)); in_y = W'(fx(b)); in_z = W'(fx(c));
        @(posedge clk); #1;
        in_valid = 0;
        in_x = W'({$urandom, $urandom}); in_y = W'({$urandom, $urandom});
        in_z = W'({$urandom, $urandom}); in_mode = ~mode;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("latency", n, PASSES);
        rx = fr(res_x); ry = fr(res_y); rz = fr(res_z);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    function automatic longint rnd_fx(input real lo, input real hi);
        return fx(lo + (hi - lo) * (real'($urandom) / 4294967295.0));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        real    rx, ry, rz;
        longint mx, my, mz;
        int     n, k;
        bit     en;

        rst = 1; clk_en = 1; in_valid = 0; in_mode = 0; out_ready = 0;
        in_x = '0; in_y = '0; in_z = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Pin the model itself on a textbook point
        model(0, 0, 0, fx(M_PI / 6.0), mx, my, mz);
        chk_real("model_cos30", real'(mx) / SCALE, 0.8660254037844386);
        chk_real("model_sin30", real'(my) / SCALE, 0.5);

        op(0, 0.0, 0.0, 0.0, rx, ry, rz);
        chk_real("rot0_x", rx, 1.0);
        chk_real("rot0_y", ry, 0.0);
        op(0, 0.0, 0.0, M_PI / 6.0, rx, ry, rz);
        chk_real("rot30_x", rx, 0.8660254037844386);
        chk_real("rot30_y", ry, 0.5);
        // (3,4) would exceed the 4-integer-bit range once scaled by An, so use (0.75,1.0)
        op(1, 0.75, 1.0, 0.0, rx, ry, rz);
        chk_real("vec_mag", rx, 2.0584503226513318);
        chk_real("vec_ang", rz, 0.9272952180016122);
`ifdef CORDIC_RANGE_RED_EN
        op(0, 0.0, 0.0, 3.0 * M_PI / 4.0, rx, ry, rz);
        chk_real("rr_rot_x", rx, -0.7071067811865476);
        chk_real("rr_rot_y", ry, 0.7071067811865476);
        op(1, -1.0, 1.0, 0.0, rx, ry, rz);
        chk_real("rr_vec_ang", rz, 2.356194490192345);
`endif

        // Backpressure: hold result, then consume and accept on the same edge
        @(posedge clk); #1;
        in_mode = 1; in_x = W'(fx(0.5)); in_y = W'(fx(-0.25)); in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("bp_latency1", n, PASSES);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_hold_valid", longint'(out_valid), 1);
        chk("bp_hold_ready", longint'(in_ready), 0);
        out_ready = 1; in_valid = 1; in_mode = 0; in_z = W'(fx(-0.7));
        @(posedge clk); #1;
        out_ready = 0; in_valid = 0;
        chk("bp_reaccept", longint'(out_valid), 0);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("bp_latency2", n, PASSES);
        out_ready = 1; @(posedge clk); #1; out_ready = 0;

        // clk_en toggling
        in_mode = 0; in_z = W'(fx(-1.0)); in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0; k = 0; en = 0;
        while (!out_valid && k < 200) begin
            clk_en = en;
            @(posedge clk); #1;
            if (en) n++;
            en = ~en; k++;
        end
        chk("clken_latency", n, PASSES);
        clk_en = 1; out_ready = 1; @(posedge clk); #1; out_ready = 0;

        // Reset pulse mid-operation
        in_mode = 0; in_z = W'(fx(0.3)); in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("rstmid_valid", longint'(out_valid), 0);
        chk("rstmid_ready", longint'(in_ready), 1);
        chk("rstmid_res_x", longint'(res_x), 0);
        @(posedge clk); #1 rst = 0;
        op(0, 0.0, 0.0, -M_PI / 4.0, rx, ry, rz);
        chk_real("post_rst_y", ry, -0.7071067811865476);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 599) == 0);
            clk_en    = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            in_mode   = $urandom_range(0, 1);
`ifdef CORDIC_RANGE_RED_EN
            in_z = W'(rnd_fx(-M_PI, M_PI));
            in_x = W'(rnd_fx(-2.0, 2.0));
`else
            in_z = W'(rnd_fx(-M_PI / 2.0, M_PI / 2.0));
            in_x = W'(rnd_fx(0.0, 2.0));
`endif
            in_y = W'(rnd_fx(-2.0, 2.0));
        end
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
